modport_fifo: RTL and testbench
===============================

Name: modport_fifo

Overview:
- Single-clock synchronous FIFO with 128-bit data words, and with write/read strobes, full/empty flags and an occupancy count.
- Standalone buffering block between a producer and a consumer that share one clock.
- Driven and monitored through a shared signal bundle named wr, rd, full, empty, fifo_cnt, D_in and D_out.

Parameters:
- DATA_W, 128, data word width in bits.
- DEPTH, 256, number of entries; must be a power of two and at least 2.
- ADDR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clock  input  1  sole clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr  input  1  write request; D_in is sampled when the write is accepted.
- rd  input  1  read request.
- D_in  input  DATA_W  write data.
- D_out  output  DATA_W  registered read data.
- full  output  1  high when fifo_cnt == DEPTH.
- empty  output  1  high when fifo_cnt == 0.
- fifo_cnt  output  ADDR_W+1  current occupancy, range 0..DEPTH. Zero-extended by any wider consumer.

Behaviour:
- Interface: one clock (clock). Reset rst is asynchronous and active-low.
- Reset (rst low, asserted asynchronously):
  - write pointer = 0, read pointer = 0, fifo_cnt = 0.
  - empty = 1, full = 0, D_out = 0.
  - Storage contents are don't-care.
  - Release is synchronous to clock: the first accepted operation happens on the first rising edge with rst high.
- Reset mid-operation discards all stored data and restores the reset values immediately.
- Write acceptance: wr_ok = wr && !full. On the rising edge, mem[wptr] <= D_in and wptr increments modulo DEPTH.
- Read acceptance: rd_ok = rd && !empty. On the rising edge, D_out <= mem[rptr] and rptr increments modulo DEPTH. Read latency is 1 cycle: data is valid on D_out after the edge that accepted rd.
- D_out holds its last value when no read is accepted.
- Count update:
  - wr_ok only: +1.
  - rd_ok only: -1.
  - both: unchanged.
  - neither: unchanged.
- Flags are registered or derived combinationally from the registered count. In either case they reflect the post-edge state in the same cycle as fifo_cnt.
- Boundary conditions:
  - Full with wr and rd both high: read accepted, write rejected. fifo_cnt becomes DEPTH-1.
  - Empty with wr and rd both high: write accepted, read rejected (no fall-through). fifo_cnt becomes 1 and D_out is unchanged.
  - Write while full: ignored; no pointer or storage change.
  - Read while empty: ignored; D_out unchanged.
  - Pointer wrap: pointers roll from DEPTH-1 to 0. Ordering is preserved across the wrap.
- X on wr or rd must not corrupt state while rst is low.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, adds two outputs, overflow (1) and underflow (1):
  - overflow sets when wr && full at a clock edge.
  - underflow sets when rd && empty at a clock edge.
  - Both are sticky until reset and cleared to 0 by rst.
- When undefined, these ports and their logic do not exist. Core behaviour is identical in both cases.

Decomposition:
- Package fifo_pkg holds:
  - localparams DATA_W_DEF = 128 and DEPTH_DEF = 256.
  - typedef logic [DATA_W_DEF-1:0] fifo_data_t.
- One natural sub-module, fifo_mem: a DEPTH x DATA_W storage array with a synchronous write port and a registered read port. The top level holds pointers, count, flags and the optional error logic.

Test Plan:
- Reset check: assert rst low mid-traffic, then release -> empty=1, full=0, fifo_cnt=0, D_out=0 immediately while rst is low.
- Write 0x1, 0x2, 0x3, then read 3 times -> D_out sequence 0x1, 0x2, 0x3, each one cycle after its rd; fifo_cnt goes 3, 2, 1, 0 and empty rises after the third read.
- Fill with 256 writes (data = index) -> full=1, fifo_cnt=256. A 257th write is ignored; draining returns 0..255 in order.
- Full, wr=rd=1 for one cycle -> fifo_cnt=255, D_out=0x0 (oldest), and the written word is not stored.
- Empty, wr=rd=1 with D_in=0xAA -> fifo_cnt=1, D_out unchanged; the next rd yields 0xAA.
- Wrap-around: 200 writes, 200 reads, then 100 writes of 0x1000+i and 100 reads -> data matches in order across the pointer wrap. With FIFO_ERR_FLAGS_EN, a read while empty sets underflow=1 until reset.

Source files
------------

// File: rtl/modport_fifo_pkg.sv
// Shared types and default sizing for the modport FIFO slice.
package fifo_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int DEPTH_DEF  = 256;

  typedef logic [DATA_W_DEF-1:0] fifo_data_t;
endpackage

// File: rtl/modport_fifo_if.sv
// Producer/consumer signal bundle for modport_fifo; overflow/underflow exist only with FIFO_ERR_FLAGS_EN.
// master = the bench/producer side, slave = the FIFO itself.
interface modport_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] D_in;
  logic [DATA_W-1:0] D_out;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   fifo_cnt;

`ifdef FIFO_ERR_FLAGS_EN
  logic              overflow;
  logic              underflow;

  modport master (output wr, rd, D_in, input D_out, full, empty, fifo_cnt, overflow, underflow);
  modport slave  (input wr, rd, D_in, output D_out, full, empty, fifo_cnt, overflow, underflow);
`else
  modport master (output wr, rd, D_in, input D_out, full, empty, fifo_cnt);
  modport slave  (input wr, rd, D_in, output D_out, full, empty, fifo_cnt);
`endif
endinterface

// File: rtl/modport_fifo_mem.sv
// fifo_mem: DEPTH x DATA_W storage, synchronous write, registered read.
// Latency: read data one cycle after re; rdat holds when re is low. No backpressure.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdat,
  input  logic                       re,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdat
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdat_q, rdat_d;

  // Storage is left unreset so it can map onto a RAM macro.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdat;
  end

  always_comb begin
    rdat_d = rdat_q;
    if (re) rdat_d = mem_q[raddr];
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) rdat_q <= '0;
    else      rdat_q <= rdat_d;
  end

  assign rdat = rdat_q;
endmodule

// File: rtl/modport_fifo.sv
// modport_fifo: single-clock FIFO; read data 1 cycle after accepted rd; writes dropped when full, reads when empty.
// Optional sticky overflow/underflow outputs under FIFO_ERR_FLAGS_EN.
module modport_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic          clock,
  input  logic          rst,
  modport_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam logic [ADDR_W:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              full, empty;
  logic              wr_ok, rd_ok;
  logic [DATA_W-1:0] rdat;

  // Flags come straight from the registered count so they always agree with fifo_cnt.
  assign full  = (cnt_q == CNT_FULL);
  assign empty = (cnt_q == '0);
  assign wr_ok = bus.wr && !full;
  assign rd_ok = bus.rd && !empty;

  always_comb begin
    wptr_d = wptr_q + ADDR_W'(wr_ok);
    rptr_d = rptr_q + ADDR_W'(rd_ok);
    cnt_d  = cnt_q;
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clock (clock),
    .rst   (rst),
    .we    (wr_ok),
    .waddr (wptr_q),
    .wdat  (bus.D_in),
    .re    (rd_ok),
    .raddr (rptr_q),
    .rdat  (rdat)
  );

  assign bus.D_out    = rdat;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.fifo_cnt = cnt_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.wr && full);
    udf_d = udf_q | (bus.rd && empty);
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
`endif
endmodule

// File: tb/tb_modport_fifo.sv
// Scoreboard bench for modport_fifo: driver feeds a queue-based model, monitor checks every cycle.
module tb_modport_fifo;
  import fifo_pkg::*;

  localparam int DEPTH = DEPTH_DEF;

  typedef struct {
    fifo_data_t dout;
    int         cnt;
    bit         ovf;
    bit         udf;
  } exp_t;

  logic clock = 1'b0;
  logic rst   = 1'b1;

  modport_fifo_if #(.DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) bus ();

  modport_fifo #(.DATA_W(DATA_W_DEF), .DEPTH(DEPTH)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t       exp_q[$];
  fifo_data_t mdl[$];
  fifo_data_t mdl_dout = '0;
  bit         mdl_ovf  = 1'b0;
  bit         mdl_udf  = 1'b0;

  task automatic chk(input string name, input fifo_data_t act, input fifo_data_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_state(input string tag, input exp_t e);
    chk({tag, ".D_out"},    bus.D_out, e.dout);
    chk({tag, ".fifo_cnt"}, fifo_data_t'(bus.fifo_cnt), fifo_data_t'(e.cnt));
    chk({tag, ".empty"},    fifo_data_t'(bus.empty), fifo_data_t'(e.cnt == 0));
    chk({tag, ".full"},     fifo_data_t'(bus.full),  fifo_data_t'(e.cnt == DEPTH));
`ifdef FIFO_ERR_FLAGS_EN
    chk({tag, ".overflow"},  fifo_data_t'(bus.overflow),  fifo_data_t'(e.ovf));
    chk({tag, ".underflow"}, fifo_data_t'(bus.underflow), fifo_data_t'(e.udf));
`endif
  endtask

  function automatic exp_t snap();
    exp_t e;
    e.dout = mdl_dout;
    e.cnt  = mdl.size();
    e.ovf  = mdl_ovf;
    e.udf  = mdl_udf;
    return e;
  endfunction

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy.
  task automatic cyc(input bit w, input bit r, input fifo_data_t d);
    int  sz;
    @(negedge clock);
    bus.wr   = w;
    bus.rd   = r;
    bus.D_in = d;
    sz = mdl.size();
    if (w && sz == DEPTH) mdl_ovf = 1'b1;
    if (r && sz == 0)     mdl_udf = 1'b1;
    if (r && sz > 0)      mdl_dout = mdl.pop_front();
    if (w && sz < DEPTH)  mdl.push_back(d);
    exp_q.push_back(snap());
  endtask

  function automatic fifo_data_t rnd_word();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic do_reset();
    @(negedge clock);
    rst    = 1'b0;
    bus.wr = 1'b1;
    bus.rd = 1'b1;
    mdl.delete();
    mdl_dout = '0;
    mdl_ovf  = 1'b0;
    mdl_udf  = 1'b0;
    #1 chk_state("reset_async", snap());
    repeat (2) @(posedge clock);
    #1 chk_state("reset_held", snap());
    @(negedge clock);
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    rst    = 1'b1;
  endtask

  // Monitor: compares DUT state after every edge that has an expectation queued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk_state("cycle", e);
      end
    end
  end

  initial begin
    int pw, pr, budget;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    bus.D_in = '0;
    #2 rst = 1'b0;
    #1 chk_state("reset_init", snap());
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst = 1'b1;

    for (int i = 1; i <= 3; i++) cyc(1'b1, 1'b0, fifo_data_t'(i));
    for (int i = 0; i < 3; i++)  cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);

    for (int i = 0; i <= DEPTH; i++) cyc(1'b1, 1'b0, fifo_data_t'(i));
    cyc(1'b1, 1'b1, fifo_data_t'(32'hDEAD));
    cyc(1'b1, 1'b0, fifo_data_t'(32'hBEEF));
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, 1'b1, '0);

    cyc(1'b1, 1'b1, fifo_data_t'(8'hAA));
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);

    for (int i = 0; i < 200; i++) cyc(1'b1, 1'b0, rnd_word());
    for (int i = 0; i < 200; i++) cyc(1'b0, 1'b1, '0);
    for (int i = 0; i < 100; i++) cyc(1'b1, 1'b0, fifo_data_t'(32'h1000 + i));
    for (int i = 0; i < 100; i++) cyc(1'b0, 1'b1, '0);

    for (int ph = 0; ph < 8; ph++) begin
      pw = (ph % 2 == 0) ? 85 : 25;
      pr = (ph % 2 == 0) ? 25 : 85;
      if (ph == 6) do_reset();
      for (int i = 0; i < 500; i++)
        cyc($urandom_range(99) < pw, $urandom_range(99) < pr, rnd_word());
    end

    while (mdl.size() > 0) cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b1, '0);
    cyc(1'b0, 1'b0, '0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 10) begin
      @(posedge clock);
      budget++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
